hpu_seq_ctrl: RTL

// - Phase sequencer for the HPU stream datapath: takes a start command plus job geometry and drives item-memory generation (matw/mat_a), then execution (run, exec, last_j, s_fin), then output drain.
// - Replaces the software-driven matw/run bit toggling of the AXI-Lite register file with a hardware FSM in the AXIS clock domain.
// - Reports busy/done/abort status back to the register file.

---
 rtl/hpu_seq_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hpu_seq_ctrl.sv
// hpu_seq_ctrl: phase sequencer for the HPU stream datapath.
// Walks a job through item-memory generation, execution and output drain,
// and reports busy/done/aborted/timeout to the register file.
// Optional build macro HPU_SEQ_TIMEOUT_EN adds a drain watchdog of
// TIMEOUT_CYC cycles; without it timeout is tied low and DRAIN waits forever.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | no job, waiting for cfg_start
// ST_GEN   | item-memory write, mat_a sweeps 0..rand_num
// ST_EXEC  | execution, one exec per accepted source beat
// ST_DRAIN | all beats consumed, waiting for the output TLAST
// ST_DONE  | job finished, done held until the next cfg_start
module hpu_seq_ctrl #(
   parameter int ADDR_W      = 20,
   parameter int MAT_W       = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              AXIS_ACLK,
   input  logic              AXIS_ARESETN,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic [MAT_W-1:0]  cfg_rand_num,
   input  logic [ADDR_W-1:0] cfg_addr_i,
   input  logic [ADDR_W-1:0] cfg_addr_j,
   input  logic              src_v,
   input  logic              dst_done,
   output logic              matw,
   output logic [MAT_W-1:0]  mat_a,
   output logic              run,
   output logic              exec,
   output logic              last_j,
   output logic              s_fin,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              timeout
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GEN,
      ST_EXEC,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t            state;
   logic [MAT_W-1:0]  rand_num_q;
   logic [ADDR_W-1:0] addr_i_q;
   logic [ADDR_W-1:0] addr_j_q;
   logic [ADDR_W-1:0] cnt_i;
   logic [ADDR_W-1:0] cnt_j;
   logic              job_active;

`ifdef HPU_SEQ_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] WD_LOAD = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] wd_cnt;
   logic            timeout_q;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   // Beat-level strobes follow src_v in the same cycle so the core sees them with its data.
   assign job_active = (state == ST_GEN) || (state == ST_EXEC) || (state == ST_DRAIN);
   assign exec       = (state == ST_EXEC) & src_v;
   assign last_j     = exec & (cnt_j == addr_j_q);
   assign s_fin      = last_j & (cnt_i == addr_i_q);

   // Sequencer FSM with registered phase/status outputs; abort takes priority over everything.
   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state      <= ST_IDLE;
         rand_num_q <= '0;
         addr_i_q   <= '0;
         addr_j_q   <= '0;
         cnt_i      <= '0;
         cnt_j      <= '0;
         matw       <= 1'b0;
         mat_a      <= '0;
         run        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
`ifdef HPU_SEQ_TIMEOUT_EN
         wd_cnt     <= '0;
         timeout_q  <= 1'b0;
`endif
      end else if (cfg_abort && job_active) begin
         state   <= ST_IDLE;
         cnt_i   <= '0;
         cnt_j   <= '0;
         matw    <= 1'b0;
         mat_a   <= '0;
         run     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b1;
`ifdef HPU_SEQ_TIMEOUT_EN
         wd_cnt  <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (cfg_start) begin
                  rand_num_q <= cfg_rand_num;
                  addr_i_q   <= cfg_addr_i;
                  addr_j_q   <= cfg_addr_j;
                  cnt_i      <= '0;
                  cnt_j      <= '0;
                  matw       <= 1'b1;
                  mat_a      <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  aborted    <= 1'b0;
`ifdef HPU_SEQ_TIMEOUT_EN
                  timeout_q  <= 1'b0;
`endif
                  state      <= ST_GEN;
               end
            end
            ST_GEN: begin
               if (mat_a == rand_num_q) begin
                  matw  <= 1'b0;
                  mat_a <= '0;
                  run   <= 1'b1;
                  state <= ST_EXEC;
               end else begin
                  mat_a <= mat_a + MAT_W'(1);
               end
            end
            ST_EXEC: begin
               if (exec) begin
                  if (last_j) begin
                     cnt_j <= '0;
                     if (s_fin) begin
                        cnt_i <= '0;
                        state <= ST_DRAIN;
`ifdef HPU_SEQ_TIMEOUT_EN
                        wd_cnt <= WD_LOAD;
`endif
                     end else begin
                        cnt_i <= cnt_i + ADDR_W'(1);
                     end
                  end else begin
                     cnt_j <= cnt_j + ADDR_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (dst_done) begin
                  run   <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
`ifdef HPU_SEQ_TIMEOUT_EN
               else if (wd_cnt == '0) begin
                  run       <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  timeout_q <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  wd_cnt <= wd_cnt - TO_W'(1);
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
